// File: rtl/hack_boot_pkg.sv
// Shared types for the Hack boot loader: FSM state encoding, instruction
// word type and the checksum seed.
package hack_boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    CK_HI,
    CK_LO,
    RUN,
    ERROR
  } boot_state_t;

  typedef logic [15:0] word_t;

  localparam word_t CKSUM_INIT = 16'h0000;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_loading(boot_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DAT_HI) ||
           (s == DAT_LO) || (s == CK_HI)  || (s == CK_LO);
  endfunction

endpackage

// File: rtl/hack_byte_pair.sv
// Big-endian byte-pair assembler: the first accepted byte is held as the
// high half, the second completes the word and raises word_valid in that
// same cycle. clr re-aligns the pairing at the start of a new image.
module hack_byte_pair
  import hack_boot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output word_t      word,
  output logic       word_valid
);

  logic [7:0] hi_q;
  logic       phase_q;

  // Capture the high byte and track which half of the pair comes next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      phase_q <= 1'b0;
    end else if (clr) begin
      phase_q <= 1'b0;
    end else if (byte_valid) begin
      if (!phase_q) hi_q <= byte_data;
      phase_q <= ~phase_q;
    end
  end

  assign word       = {hi_q, byte_data};
  assign word_valid = byte_valid && phase_q;

endmodule

// File: rtl/hack_boot_loader.sv
// Hack CPU boot sequencer: receives LEN, N instruction words and an
// optional checksum as a big-endian byte stream, writes the words into
// instruction ROM from address 0 and then releases the CPU from reset.
// Optional feature macro: HACK_BOOT_CKSUM_EN (16-bit checksum trailer).
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef logic [16:0] count_t;

  localparam count_t CAP = count_t'(1) << ROM_AW;
`ifdef HACK_BOOT_CKSUM_EN
  localparam boot_state_t POST_DATA = CK_HI;
`else
  localparam boot_state_t POST_DATA = RUN;
`endif

  boot_state_t state_q, state_n;
  word_t       len_q;
  count_t      idx_q;
  word_t       pair_word;
  logic        pair_valid;
  logic        fire;
  logic        start_ok;

  assign fire     = rx_valid && rx_ready;
  assign start_ok = start && !is_loading(state_q);

  hack_byte_pair u_pair (
    .clk        (clk),
    .reset      (reset),
    .clr        (start_ok),
    .byte_valid (fire),
    .byte_data  (rx_data),
    .word       (pair_word),
    .word_valid (pair_valid)
  );

`ifdef HACK_BOOT_CKSUM_EN
  word_t sum_q;

  // Running mod-2^16 sum of data words, restarted with each load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= CKSUM_INIT;
    end else if (start_ok) begin
      sum_q <= CKSUM_INIT;
    end else if (state_q == DAT_LO && pair_valid) begin
      sum_q <= sum_q + pair_word;
    end
  end
`endif

  // Next-state decode driven by completed byte pairs.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE, RUN, ERROR: if (start) state_n = LEN_HI;
      LEN_HI:           if (fire) state_n = LEN_LO;
      LEN_LO: begin
        if (pair_valid) begin
          if ({1'b0, pair_word} > CAP)  state_n = ERROR;
          else if (pair_word == '0)     state_n = POST_DATA;
          else                          state_n = DAT_HI;
        end
      end
      DAT_HI:           if (fire) state_n = DAT_LO;
      DAT_LO: begin
        if (pair_valid) begin
          if (idx_q + 17'd1 == {1'b0, len_q}) state_n = POST_DATA;
          else                                state_n = DAT_HI;
        end
      end
`ifdef HACK_BOOT_CKSUM_EN
      CK_HI:            if (fire) state_n = CK_LO;
      CK_LO: begin
        if (pair_valid) state_n = (pair_word == sum_q) ? RUN : ERROR;
      end
`endif
      default:          state_n = IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so that
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_n;
      rx_ready  <= is_loading(state_n);
      busy      <= is_loading(state_n);
      done      <= (state_n == RUN);
      err       <= (state_n == ERROR);
      cpu_reset <= (state_n != RUN);
      rom_we    <= 1'b0;
      if (start_ok) idx_q <= '0;
      if (state_q == LEN_LO && pair_valid) len_q <= pair_word;
      if (state_q == DAT_LO && pair_valid) begin
        rom_we    <= 1'b1;
        rom_addr  <= idx_q[ROM_AW-1:0];
        rom_wdata <= pair_word;
        idx_q     <= idx_q + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader with a 16-word ROM (ROM_AW=4).
// Builds with or without HACK_BOOT_CKSUM_EN; the trailer is sent accordingly.
module tb_hack_boot_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, rom_we, cpu_reset, busy, done, err;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  logic [AW-1:0] wq_addr[$];
  logic [15:0]   wq_data[$];

  always #5 clk = ~clk;

  hack_boot_loader #(.ROM_AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ROM write log, one entry per cycle that rom_we is high.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wq_addr.push_back(rom_addr);
      wq_data.push_back(rom_wdata);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte (after an optional idle gap) and return at the
  // falling edge following its transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    n_checks++;
    if (t >= 50) begin n_fail++; $display("FAIL send_timeout: rx_ready never high for byte %02h", b); end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] w[$], input int maxgap);
    logic [15:0] n;
    logic [15:0] sum;
    sum = 16'h0000;
    n = 16'(w.size());
    send_byte(n[15:8], $urandom_range(maxgap, 0));
    send_byte(n[7:0],  $urandom_range(maxgap, 0));
    foreach (w[i]) begin
      send_byte(w[i][15:8], $urandom_range(maxgap, 0));
      send_byte(w[i][7:0],  $urandom_range(maxgap, 0));
      sum = sum + w[i];
    end
`ifdef HACK_BOOT_CKSUM_EN
    send_byte(sum[15:8], $urandom_range(maxgap, 0));
    send_byte(sum[7:0],  $urandom_range(maxgap, 0));
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    n_checks++; if (rom_we !== 1'b0) begin n_fail++; $display("FAIL reset_rom_we: got %b want 0", rom_we); end
    n_checks++; if (rom_addr !== 4'h0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_checks++; if (rom_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rom_wdata: got %h want 0000", rom_wdata); end
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got busy/done/err=%b want 000", {busy, done, err}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    wq_addr.delete(); wq_data.delete(); stalls = 0;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy); end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h30, 0); send_byte(8'h39, 0);
    send_byte(8'hEC, 0);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL load_cpu_reset_early: got %b want 1", cpu_reset); end
    send_byte(8'h10, 0);
`ifdef HACK_BOOT_CKSUM_EN
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL load_cpu_reset_pre_ck: got %b want 1", cpu_reset); end
    send_byte(8'h1C, 0); send_byte(8'h49, 0);
`else
    n_checks++; if (rom_we !== 1'b1) begin n_fail++; $display("FAIL load_last_we_with_release: got %b want 1", rom_we); end
`endif
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL load_cpu_release: got %b want 0", cpu_reset); end
    n_checks++; if ({busy, done, err, rx_ready} !== 4'b0100) begin n_fail++; $display("FAIL load_status: got busy/done/err/rdy=%b want 0100", {busy, done, err, rx_ready}); end
    n_checks++; if (stalls !== 0) begin n_fail++; $display("FAIL load_back_to_back: got %0d stall cycles want 0", stalls); end
    @(negedge clk);
    n_checks++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL load_write_count: got %0d want 2", wq_addr.size()); end
    else begin
      n_checks++; if (wq_addr[0] !== 4'h0 || wq_data[0] !== 16'h3039) begin n_fail++; $display("FAIL load_word0: got %h@%h want 3039@0", wq_data[0], wq_addr[0]); end
      n_checks++; if (wq_addr[1] !== 4'h1 || wq_data[1] !== 16'hEC10) begin n_fail++; $display("FAIL load_word1: got %h@%h want EC10@1", wq_data[1], wq_addr[1]); end
    end
  endtask

`ifdef HACK_BOOT_CKSUM_EN
  task automatic test_cksum_mismatch();
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h30, 0); send_byte(8'h39, 0);
    send_byte(8'hEC, 0); send_byte(8'h10, 0);
    send_byte(8'h1C, 0); send_byte(8'h48, 0);
    repeat (3) @(negedge clk);
    n_checks++; if ({err, cpu_reset, done, busy} !== 4'b1100) begin n_fail++; $display("FAIL ck_err_status: got err/cpurst/done/busy=%b want 1100", {err, cpu_reset, done, busy}); end
    n_checks++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL ck_write_count: got %0d want 2", wq_addr.size()); end
    pulse_start();
    n_checks++; if ({err, busy, cpu_reset} !== 3'b011) begin n_fail++; $display("FAIL ck_restart: got err/busy/cpurst=%b want 011", {err, busy, cpu_reset}); end
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
  endtask
`endif

  task automatic test_zero_len();
    logic [15:0] img[$];
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_image(img, 0);
    n_checks++; if ({done, err, cpu_reset} !== 3'b100) begin n_fail++; $display("FAIL zero_len_status: got done/err/cpurst=%b want 100", {done, err, cpu_reset}); end
    @(negedge clk);
    n_checks++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL zero_len_writes: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_oversize();
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h11, 0);
    n_checks++; if ({err, cpu_reset, busy, rx_ready} !== 4'b1100) begin n_fail++; $display("FAIL oversize_status: got err/cpurst/busy/rdy=%b want 1100", {err, cpu_reset, busy, rx_ready}); end
    repeat (3) @(negedge clk);
    n_checks++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL oversize_writes: got %0d want 0", wq_addr.size()); end
  endtask

  task automatic test_full_capacity();
    logic [15:0] img[$];
    int bad;
    for (int i = 0; i < 16; i++) img.push_back(16'h1111 * 16'(i) + 16'h0F01);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_image(img, 0);
    n_checks++; if ({done, err, cpu_reset} !== 3'b100) begin n_fail++; $display("FAIL full_status: got done/err/cpurst=%b want 100", {done, err, cpu_reset}); end
    @(negedge clk);
    n_checks++; if (wq_addr.size() !== 16) begin n_fail++; $display("FAIL full_write_count: got %0d want 16", wq_addr.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (wq_addr[i] !== 4'(i) || wq_data[i] !== img[i]) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_contents: got %0d wrong words want 0", bad); end
    end
  endtask

  task automatic test_throttle();
    logic [15:0] img[$];
    int bad;
    img = '{16'h1234, 16'hABCD, 16'h0F0F};
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_image(img, 3);
    n_checks++; if ({done, cpu_reset} !== 2'b10) begin n_fail++; $display("FAIL throttle_status: got done/cpurst=%b want 10", {done, cpu_reset}); end
    @(negedge clk);
    n_checks++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL throttle_write_count: got %0d want 3", wq_addr.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 3; i++)
        if (wq_addr[i] !== 4'(i) || wq_data[i] !== img[i]) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL throttle_contents: got %0d wrong words want 0", bad); end
    end
    rx_valid = 1'b1; rx_data = 8'h5A;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    n_checks++; if (bad !== 0 || wq_addr.size() !== 3) begin n_fail++; $display("FAIL run_rx_ready: got %0d ready cycles, %0d writes want 0, 3", bad, wq_addr.size()); end
  endtask

  task automatic test_reload();
    pulse_start();
    n_checks++; if ({cpu_reset, busy, done, rx_ready} !== 4'b1101) begin n_fail++; $display("FAIL reload_status: got cpurst/busy/done/rdy=%b want 1101", {cpu_reset, busy, done, rx_ready}); end
  endtask

  task automatic test_reset_midload();
    int bad;
    // Loader is in LEN_HI after test_reload.
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    n_checks++; if (rom_we !== 1'b1 || rom_wdata !== 16'h1234) begin n_fail++; $display("FAIL midload_word1: got we=%b data=%h want 1, 1234", rom_we, rom_wdata); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({cpu_reset, rx_ready, rom_we, busy, done, err} !== 6'b100000) begin n_fail++; $display("FAIL midload_async_status: got %b want 100000", {cpu_reset, rx_ready, rom_we, busy, done, err}); end
    n_checks++; if (rom_addr !== 4'h0 || rom_wdata !== 16'h0000) begin n_fail++; $display("FAIL midload_async_rom: got %h@%h want 0000@0", rom_wdata, rom_addr); end
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h56;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midload_idle_after: got %0d non-idle cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_load();
`ifdef HACK_BOOT_CKSUM_EN
    test_cksum_mismatch();
`endif
    test_zero_len();
    test_oversize();
    test_full_capacity();
    test_throttle();
    test_reload();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_boot_loader.md
# hack_boot_loader

Boot sequencer for the Hack CPU. It holds the CPU in reset and receives a program image as an 8-bit byte stream. It assembles 16-bit instructions, writes them into instruction ROM from address 0, and then releases the CPU so it begins fetching at pcaddr 0. It sits between the host byte link (UART receiver) and the CPU/ROM pair, and owns the CPU `reset` input.

## Interface
Parameters:
- ROM_AW, 15: instruction ROM address width. Capacity is 2^ROM_AW words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a new load.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte. A byte transfers on a cycle where rx_valid && rx_ready.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ROM_AW  ROM write address.
- rom_wdata  out  16  instruction word to write.
- cpu_reset  out  1  drives the CPU `reset` input.
- busy  out  1  a load is in progress.
- done  out  1  the image was loaded and the CPU is running.
- err  out  1  the load failed; the CPU stays in reset.

## Operation
- Image format, all fields big-endian (high byte first):
  - LEN: 16 bits, the word count N.
  - N instruction words.
  - CKSUM: 16 bits, present only when configured in.
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CK_HI, CK_LO, RUN, ERROR.
- IDLE:
  - cpu_reset=1, rx_ready=0.
  - start moves to LEN_HI.
- LEN_HI and LEN_LO:
  - Each accepts one byte into the count register.
  - On leaving LEN_LO:
    - N > 2^ROM_AW: go to ERROR.
    - N == 0: go to CK_HI, or to RUN when checksum is not configured.
    - Otherwise: go to DAT_HI.
- DAT_HI and DAT_LO:
  - DAT_HI latches the high byte.
  - Accepting the DAT_LO byte registers rom_wdata = {hi, lo} and rom_addr = word index, and pulses rom_we for one cycle.
  - The word index then increments.
  - When word index reaches N, go to CK_HI (or to RUN); otherwise go back to DAT_HI.
- CK_HI and CK_LO:
  - Compare the received value against the running sum of all data words, mod 2^16.
  - Match goes to RUN; mismatch goes to ERROR.
- RUN:
  - cpu_reset=0, done=1.
  - start re-enters LEN_HI, which reasserts cpu_reset.
- ERROR:
  - cpu_reset=1, err=1.
  - Exit only via start, which goes to LEN_HI and clears err.
- busy=1 in LEN_HI through CK_LO.
- rx_ready=1 exactly in LEN_HI through CK_LO.
- Bytes presented while rx_ready=0 are left pending, not dropped.
- start during a load (busy=1) is ignored.
- The word index wraps at ROM_AW bits only in the case N == 2^ROM_AW, after the final write.

## Timing
- Reset values: cpu_reset=1, rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, busy=0, done=0, err=0. State is IDLE.
- All outputs are registered.
- rom_we rises in the cycle after the DAT_LO byte handshake and lasts exactly 1 cycle.
- rom_addr and rom_wdata are valid while rom_we=1.
- Back-to-back bytes are accepted at 1 byte per cycle, so the maximum rate is 1 word per 2 cycles.
- cpu_reset falls in the cycle after the final accepted byte (the last DAT_LO byte, or CK_LO when checksum is configured). The CPU's first fetch of address 0 follows on the next edge.
- The final rom_we and the cpu_reset deassertion happen in the same cycle. The ROM must accept a write in the same cycle the CPU leaves reset.
- reset asserted mid-load aborts immediately:
  - All outputs return to their reset values.
  - ROM contents are left partially written.
  - The host must restart with start.

## Configuration
- HACK_BOOT_CKSUM_EN defined:
  - The CK_HI and CK_LO states and the 16-bit sum register exist.
  - A mismatch leads to ERROR.
  - N == 0 still requires a CKSUM field of 0x0000.
- HACK_BOOT_CKSUM_EN undefined:
  - No trailer and no sum register.
  - The last data word (or LEN_LO when N == 0) goes directly to RUN.
  - err is set only for an oversize N.

## Structure
- Shared package hack_boot_pkg holds:
  - the state encoding typedef;
  - the 16-bit word type;
  - the localparam CKSUM_INIT = 16'h0000.
- Sub-module hack_byte_pair assembles big-endian byte pairs into 16-bit words with a valid strobe. It is used for LEN, DAT and CK.

## Test plan
- Load with checksum configured:
  - Stimulus: start, then bytes 00 02 30 39 EC 10 1C 49.
  - Response: rom_we at addr 0 writing 0x3039, and at addr 1 writing 0xEC10.
  - cpu_reset falls 1 cycle after the final byte; done=1.
- Checksum mismatch:
  - Stimulus: same image with trailer 1C 48.
  - Response: err=1, cpu_reset stays 1, no further writes.
  - A following start clears err.
- Oversize count:
  - Stimulus: ROM_AW=4, LEN = 00 11.
  - Response: ERROR entered after the LEN_LO byte; rom_we is never asserted.
- Throttled input:
  - Stimulus: rx_valid toggled randomly.
  - Response: the written words are identical to the throttled-free load; rx_ready is 0 in IDLE and RUN.
- Reset mid-load:
  - Stimulus: assert reset after word 1 of 3.
  - Response: all outputs return to their reset values asynchronously; state is IDLE.
- Reload from RUN:
  - Stimulus: start while in RUN.
  - Response: cpu_reset rises 1 cycle later; busy=1; done=0.
